// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: opcodes, branch conditions and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-and-add multiplier retiring MUL_BITS multiplier bits per cycle.
module alu_mul_iter #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned STEPS = WIDTH / MUL_BITS;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = CW'(STEPS);
    end else if (cnt_q != '0) begin
      // Only the low WIDTH bits of the product are kept, so truncation is harmless.
      acc_d    = acc_q + mcand_q * WIDTH'(mplier_q[MUL_BITS-1:0]);
      mcand_d  = mcand_q << MUL_BITS;
      mplier_d = mplier_q >> MUL_BITS;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done    = (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe_param.sv
// Handshaked ALU with registered result, branch compare and an iterative multiplier.
module alu_pipe_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             ZERO,
  output logic             branch_taken
);

  localparam int unsigned SHW = $clog2(WIDTH);

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0 || (WIDTH % MUL_BITS) != 0) begin : g_param_check
    $error("alu_pipe_param: WIDTH must be a power of two >= 8 and divisible by MUL_BITS");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             br_q, br_d;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic             br_res;
  logic [SHW-1:0]   shamt;

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_res = 1'b0;
    case (funct3)
      BR_BEQ:  br_res = (a == b);
      BR_BNE:  br_res = (a != b);
      BR_BLT:  br_res = ($signed(a) <  $signed(b));
      BR_BGE:  br_res = ($signed(a) >= $signed(b));
      BR_BLTU: br_res = (a <  b);
      BR_BGEU: br_res = (a >= b);
      default: br_res = 1'b0;
    endcase
  end

  // accept can only be true in IDLE or in DONE with out_ready, so one branch covers both.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    br_d      = br_q;
    mul_start = 1'b0;
    if (state_q == MUL_BUSY) begin
      if (mul_done) begin
        result_d = mul_product;
        zero_d   = (mul_product == '0);
        state_d  = DONE;
      end
    end else if (accept) begin
      br_d = br_res;
      if (ALUOp == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = MUL_BUSY;
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        state_d  = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      br_q     <= br_d;
    end
  end

  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign out_valid    = (state_q == DONE);
  assign Result       = result_q;
  assign ZERO         = zero_q;
  assign branch_taken = br_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param: directed corner cases plus randomized traffic.
module tb_alu_pipe_param;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   ALUOp = '0;
  logic [2:0]   funct3 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Result;
  logic         ZERO;
  logic         branch_taken;

  always #5 clk = ~clk;

  alu_pipe_param #(.WIDTH(W), .MUL_BITS(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .ALUOp        (ALUOp),
    .funct3       (funct3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Result       (Result),
    .ZERO         (ZERO),
    .branch_taken (branch_taken)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         br;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   rand_bp = 1'b0;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [2:0] f);
    exp_t        e;
    int unsigned sh;
    sh = y % W;
    case (op)
      4'b0000: e.r = x & y;
      4'b0001: e.r = x | y;
      4'b0010: e.r = x + y;
      4'b0110: e.r = x - y;
      4'b1100: e.r = ~(x | y);
      4'b1000: e.r = x << sh;
      4'b1001: e.r = x >> sh;
      4'b1010: e.r = $signed(x) >>> sh;
      4'b0111: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'b0011: e.r = x * y;
      default: e.r = '0;
    endcase
    e.z = (e.r == 0);
    case (f)
      3'b000:  e.br = (x == y);
      3'b001:  e.br = (x != y);
      3'b100:  e.br = ($signed(x) < $signed(y));
      3'b101:  e.br = !($signed(x) < $signed(y));
      3'b110:  e.br = (x < y);
      3'b111:  e.br = !(x < y);
      default: e.br = 1'b0;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [2:0] f);
    ALUOp = op; a = x; b = y; funct3 = f; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(op, x, y, f));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tests++; fails++;
    $display("FAIL issue_timeout: in_ready never rose for op %b", op);
    in_valid = 1'b0;
  endtask

  exp_t pop_e;
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: result %h with empty scoreboard", Result);
      end else begin
        pop_e = q.pop_front();
        chk("sb_result", Result, pop_e.r);
        chk("sb_zero", W'(ZERO), W'(pop_e.z));
        chk("sb_branch", W'(branch_taken), W'(pop_e.br));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  logic [3:0] ops[11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000,
                          4'b1001, 4'b1010, 4'b0111, 4'b0011, 4'b0100};

  initial begin : main
    int cyc;
    int bad;
    logic [W-1:0] x, y;
    logic [3:0]   op;

    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_result", Result, '0);
    chk("rst_zero", W'(ZERO), '0);
    chk("rst_branch", W'(branch_taken), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset from a held DONE result
    out_ready = 1'b0;
    issue(4'b0010, 64'd7, 64'd9, 3'b000);
    chk("hold_valid", W'(out_valid), W'(1));
    chk("hold_in_ready", W'(in_ready), '0);
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    chk("async_out_valid", W'(out_valid), '0);
    chk("async_result", Result, '0);
    chk("async_in_ready", W'(in_ready), W'(1));
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000);
    chk("add_valid", W'(out_valid), W'(1));
    chk("add_result", Result, '0);
    chk("add_zero", W'(ZERO), W'(1));
    chk("add_branch", W'(branch_taken), '0);
    @(posedge clk); #1;

    issue(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 3'b100);
    chk("sub_result", Result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_branch", W'(branch_taken), W'(1));
    @(posedge clk); #1;

    issue(4'b0011, 64'd12345, 64'd678, 3'b000);
    cyc = 0; bad = 0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) bad++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("mul_latency", W'(cyc), W'(17));
    chk("mul_busy_ready", W'(bad), '0);
    chk("mul_result", Result, 64'd8369910);
    @(posedge clk); #1;

    out_ready = 1'b0;
    issue(4'b1010, 64'hF000_0000_0000_0000, 64'd4, 3'b000);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (Result !== 64'hFF00_0000_0000_0000 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    chk("bp_hold", W'(bad), '0);
    out_ready = 1'b1;
    issue(4'b0001, 64'h00F0, 64'h0F0F, 3'b001);
    chk("bp_next_valid", W'(out_valid), W'(1));
    chk("bp_next_result", Result, 64'h0FFF);
    @(posedge clk); #1;

    issue(4'b0011, 64'd999, 64'd1001, 3'b000);
    repeat (4) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    q.delete();
    #4 reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("abort_no_valid", W'(bad), '0);
    chk("abort_idle", W'(in_ready), W'(1));
    @(posedge clk); #1;
    issue(4'b0010, 64'd2, 64'd3, 3'b000);
    chk("abort_add_valid", W'(out_valid), W'(1));
    chk("abort_add_result", Result, 64'd5);
    @(posedge clk); #1;

    rand_bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 10)];
      x  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = W'($urandom_range(0, 70));
        2:       y = ~x;
        default: y = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0) x = '0;
      issue(op, x, y, 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 200) begin
      @(posedge clk); cyc++;
    end
    #2;
    chk("drain_empty", W'(q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
